ks_carry_pipe: RTL and testbench
================================

Name: ks_carry_pipe

Overview:
- Pipelined Kogge-Stone prefix carry network and sum stage for the 128-bit NTT datapath adder.
- Directly downstream of the per-bit propagate/generate stage; consumes its p = x^y and g = x&y vectors plus a carry-in.
- Produces the 128-bit sum and carry-out.
- Valid/ready handshake on both sides; configurable register placement between the 7 prefix levels.

Parameters:
- W, 128, operand width; fixed at 128 (7 prefix levels); other values are unsupported.
- REG_EVERY, 2, pipeline register after every prefix level k (1..6) with k % REG_EVERY == 0; legal range 1..7.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  p/g/cin valid this cycle
- in_ready  output  1  block accepts input this cycle
- p  input  128  propagate vector (x^y)
- g  input  128  generate vector (x&y)
- cin  input  1  carry into bit 0
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts output
- sum  output  128  sum bits
- cout  output  1  carry out of bit 127

Behaviour:
- Reset (async assert, sync release): every valid bit in the pipe cleared; out_valid=0; sum=0; cout=0. in_ready=1 after reset.
- Carry injection: before level 1, g'[0] = g[0] | (p[0] & cin); p' = p; g'[i] = g[i] for i>0. The original p and cin are carried alongside the data through every pipeline register.
- Level k (k=1..7), distance d = 2^(k-1):
  - for i>=d: G[i] = G[i] | (P[i] & G[i-d]); P[i] = P[i] & P[i-d];
  - for i<d: G[i] and P[i] pass through unchanged.
- After level 7, carry into bit i:
  - c[0] = cin; c[i] = G[i-1] for i>=1;
  - sum[i] = p[i] ^ c[i];
  - cout = G[127].
- Output register always present after the sum logic.
- Latency LAT = floor(6/REG_EVERY) + 1 cycles from accepted input to out_valid.
  - REG_EVERY=2 gives 4 cycles; REG_EVERY=1 gives 7; REG_EVERY>=7 gives 1.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Global stall: stall = out_valid & ~out_ready; in_ready = ~stall.
  - During stall, all pipeline registers, including valid bits and the output, hold; sum/cout stay stable.
  - When not stalled, every stage advances by one each cycle. Bubbles (valid=0) propagate and are not compressed.
  - Data registers load only when their incoming valid is 1; valid bits always update when not stalled.
- Throughput: one result per cycle while out_ready=1.
- Simultaneous events: output drain and input accept in the same cycle are legal and required when out_ready=1.
- Arithmetic: pure binary add, no modular reduction. Overflow is reported only through cout.
- Reset mid-operation: all in-flight results discarded and no partial output emitted; out_valid falls asynchronously with rst_n.
- Inputs with in_valid=0 are ignored; X on p/g is allowed while in_valid=0.

Decomposition:
- Shared package ntt_add_pkg:
  - ADD_W = 128
  - KS_LEVELS = 7
  - typedef of a {p, g} vector pair carried between stages
- One natural sub-module: ks_cell.
  - Inputs: (Pi, Gi, Pj, Gj). Outputs: P = Pi&Pj, G = Gi|(Pi&Gj).
  - Instantiated per bit per level via generate; pass-through bits use wires, not cells.
- Pipeline registers and the stall/valid chain stay in the top module.

Test Plan:
- x=y=all-ones (p=0, g=all-ones), cin=0 -> after 4 cycles (REG_EVERY=2): sum=0xFFFF...FFFE, cout=1, out_valid=1 exactly one cycle.
- p=all-ones, g=0, cin=1 (full ripple) -> sum=0, cout=1; same vector with cin=0 -> sum=all-ones, cout=0.
- Back-to-back stream of 16 random (x,y,cin), p/g derived in bench, out_ready=1 -> 16 consecutive out_valid cycles matching x+y+cin reference, no gaps.
- Hold out_ready=0 for 5 cycles with a full pipe -> in_ready=0, sum/cout stable and unchanged. On release, results drain in order, none lost or duplicated.
- Assert rst_n=0 mid-stream with 3 results in flight -> out_valid=0 and sum=0 immediately. After release, no stale results appear and the next input yields a correct sum at LAT.
- Rerun the random stream with REG_EVERY=1 and REG_EVERY=7 -> latency 7 and 1 cycles respectively, identical results.

Source files
------------

// File: rtl/ntt_add_pkg.sv
// Shared widths and stage types for the 128-bit NTT adder datapath.
package ntt_add_pkg;

  localparam int ADD_W     = 128;
  localparam int KS_LEVELS = 7;

  // Running group propagate/generate pair handed from one prefix level to the next.
  typedef struct packed {
    logic [ADD_W-1:0] p;
    logic [ADD_W-1:0] g;
  } pg_t;

endpackage

// File: rtl/ks_cell.sv
// Kogge-Stone black cell: merges group (pi,gi) with the lower group (pj,gj).
module ks_cell (
  input  logic pi,
  input  logic gi,
  input  logic pj,
  input  logic gj,
  output logic p,
  output logic g
);

  assign p = pi & pj;
  assign g = gi | (pi & gj);

endmodule

// File: rtl/ks_carry_pipe.sv
// Pipelined Kogge-Stone carry network plus sum stage, with a global stall on the
// valid/ready handshake and optional registers between the seven prefix levels.
module ks_carry_pipe
  import ntt_add_pkg::*;
#(
  parameter int W         = ADD_W,
  parameter int REG_EVERY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] p,
  input  logic [W-1:0] g,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NL = KS_LEVELS;

  // st[k]/st_src[k]/st_c[k]/st_v[k]: everything entering prefix level k+1.
  pg_t [NL-1:0]          st;
  logic [NL-1:0][W-1:0]  st_src;
  logic [NL-1:0]         st_c;
  logic [NL-1:0]         st_v;
  pg_t [NL:1]            lv;

  logic stall;
  logic adv;
  logic unused_top_p;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // Folding cin into bit 0 lets the prefix tree treat it as an ordinary generate.
  assign st[0].p   = p;
  assign st[0].g   = {g[W-1:1], g[0] | (p[0] & cin)};
  assign st_src[0] = p;
  assign st_c[0]   = cin;
  assign st_v[0]   = in_valid;

  for (genvar k = 1; k <= NL; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);

    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= D) begin : g_cell
        ks_cell u_cell (
          .pi(st[k-1].p[i]),
          .gi(st[k-1].g[i]),
          .pj(st[k-1].p[i-D]),
          .gj(st[k-1].g[i-D]),
          .p (lv[k].p[i]),
          .g (lv[k].g[i])
        );
      end else begin : g_pass
        assign lv[k].p[i] = st[k-1].p[i];
        assign lv[k].g[i] = st[k-1].g[i];
      end
    end

    if (k < NL) begin : g_bnd
      if (k % REG_EVERY == 0) begin : g_reg
        pg_t          r_pg;
        logic [W-1:0] r_src;
        logic         r_c;
        logic         r_v;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_v   <= 1'b0;
            r_pg  <= '0;
            r_src <= '0;
            r_c   <= 1'b0;
          end else if (adv) begin
            r_v <= st_v[k-1];
            if (st_v[k-1]) begin
              r_pg  <= lv[k];
              r_src <= st_src[k-1];
              r_c   <= st_c[k-1];
            end
          end
        end

        assign st[k]     = r_pg;
        assign st_src[k] = r_src;
        assign st_c[k]   = r_c;
        assign st_v[k]   = r_v;
      end else begin : g_wire
        assign st[k]     = lv[k];
        assign st_src[k] = st_src[k-1];
        assign st_c[k]   = st_c[k-1];
        assign st_v[k]   = st_v[k-1];
      end
    end
  end

  // Group propagate out of the last level has no consumer.
  assign unused_top_p = ^lv[NL].p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (adv) begin
      out_valid <= st_v[NL-1];
      if (st_v[NL-1]) begin
        sum  <= st_src[NL-1] ^ {lv[NL].g[W-2:0], st_c[NL-1]};
        cout <= lv[NL].g[W-1];
      end
    end
  end

endmodule

// File: tb/tb_ks_carry_pipe.sv
// Scoreboard bench: three instances (REG_EVERY 2, 1, 7) fed from shared p/g/cin.
module tb_ks_carry_pipe;

  localparam int W      = 128;
  localparam int LAT_R2 = 4;
  localparam int LAT_R1 = 7;
  localparam int LAT_R7 = 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           exp_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] p_in;
  logic [W-1:0] g_in;
  logic         cin_in;
  logic [2:0]   ivld;
  logic [2:0]   ordy;
  logic [2:0]   irdy;
  logic [2:0]   ov;
  logic [2:0]   co;
  logic [W-1:0] s [3];
  logic [W-1:0] ones;
  exp_t         q [3][$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ks_carry_pipe #(.W(W), .REG_EVERY(2)) u_dut_r2 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[0]), .in_ready(irdy[0]),
    .p(p_in), .g(g_in), .cin(cin_in), .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(s[0]), .cout(co[0]));

  ks_carry_pipe #(.W(W), .REG_EVERY(1)) u_dut_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[1]), .in_ready(irdy[1]),
    .p(p_in), .g(g_in), .cin(cin_in), .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(s[1]), .cout(co[1]));

  ks_carry_pipe #(.W(W), .REG_EVERY(7)) u_dut_r7 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[2]), .in_ready(irdy[2]),
    .p(p_in), .g(g_in), .cin(cin_in), .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(s[2]), .cout(co[2]));

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic [W-1:0] pv, input logic [W-1:0] gv, input logic c,
                       input logic [W-1:0] esum, input logic ecout, input bit aux, input bit lat);
    exp_t e;
    int   waits = 0;
    @(negedge clk);
    p_in   = pv;
    g_in   = gv;
    cin_in = c;
    ivld   = {aux, aux, 1'b1};
    #1;
    while (!irdy[0] && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!irdy[0]) begin
      n_chk++;
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, expected 1", waits);
      ivld = 3'b000;
      return;
    end
    e.sum     = esum;
    e.cout    = ecout;
    e.exp_cyc = lat ? cyc + LAT_R2 : -1;
    q[0].push_back(e);
    if (aux) begin
      e.exp_cyc = cyc + LAT_R1;
      q[1].push_back(e);
      e.exp_cyc = cyc + LAT_R7;
      q[2].push_back(e);
    end
  endtask

  task automatic drive_xy(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input bit aux, input bit lat);
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    drive(x ^ y, x & y, c, t[W-1:0], t[W], aux, lat);
  endtask

  task automatic idle();
    @(negedge clk);
    ivld   = 3'b000;
    p_in   = 'x;
    g_in   = 'x;
    cin_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    #3;
    check("drain_outstanding", W'(q[0].size() + q[1].size() + q[2].size()), '0);
  endtask

  initial begin
    ones   = '1;
    rst_n  = 1'b0;
    ivld   = 3'b000;
    ordy   = 3'b111;
    p_in   = '0;
    g_in   = '0;
    cin_in = 1'b0;

    fork
      forever begin
        @(negedge clk);
        #2;
        if (rst_n) begin
          for (int d = 0; d < 3; d++) begin
            if (ov[d]) begin
              if (q[d].size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out dut%0d: out_valid=1 sum=%h, expected no output", d, s[d]);
              end else begin
                check($sformatf("sum dut%0d", d), s[d], q[d][0].sum);
                check($sformatf("cout dut%0d", d), W'(co[d]), W'(q[d][0].cout));
                if (ordy[d]) begin
                  if (q[d][0].exp_cyc >= 0)
                    check($sformatf("latency dut%0d", d), W'(cyc), W'(q[d][0].exp_cyc));
                  void'(q[d].pop_front());
                end
              end
            end
          end
        end
      end
    join_none

    #1;
    check("rst_out_valid", W'(ov), '0);
    check("rst_sum", s[0], '0);
    check("rst_cout", W'(co), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", W'(irdy), W'(3'b111));

    // all-ones plus all-ones, then the full-ripple pair
    drive('0, ones, 1'b0, {{(W-1){1'b1}}, 1'b0}, 1'b1, 1'b0, 1'b1);
    idle();
    wait_drain();
    repeat (3) @(negedge clk);
    drive(ones, '0, 1'b1, '0, 1'b1, 1'b0, 1'b1);
    drive(ones, '0, 1'b0, ones, 1'b0, 1'b0, 1'b1);
    idle();
    wait_drain();

    // back-to-back stream into all three pipe depths
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         c;
      case (i)
        0: begin x = {(W/2){2'b10}}; y = {(W/2){2'b01}}; c = 1'b1; end
        1: begin x = {1'b1, {(W-1){1'b0}}}; y = {1'b1, {(W-1){1'b0}}}; c = 1'b0; end
        2: begin x = '0; y = '0; c = 1'b1; end
        3: begin x = {{(W/2){1'b0}}, {(W/2){1'b1}}}; y = {{(W-1){1'b0}}, 1'b1}; c = 1'b0; end
        default: begin
          x = {$urandom(), $urandom(), $urandom(), $urandom()};
          y = {$urandom(), $urandom(), $urandom(), $urandom()};
          c = 1'($urandom_range(0, 1));
        end
      endcase
      drive_xy(x, y, c, 1'b1, 1'b1);
    end
    idle();
    wait_drain();
    repeat (5) @(negedge clk);

    // fill the pipe, then hold the consumer off for five cycles
    ordy[0] = 1'b0;
    for (int i = 0; i < 4; i++)
      drive_xy({$urandom(), $urandom(), $urandom(), $urandom()},
               {$urandom(), $urandom(), $urandom(), $urandom()}, 1'(i & 1), 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", W'(irdy[0]), '0);
      check("stall_out_valid", W'(ov[0]), W'(1'b1));
      if (i < 4) @(negedge clk);
    end
    ordy[0] = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);

    // reset with three results still in flight
    for (int i = 0; i < 5; i++)
      drive_xy({$urandom(), $urandom(), $urandom(), $urandom()},
               {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b0, 1'b1);
    idle();
    #3;
    check("inflight_before_rst", W'(q[0].size()), W'(3));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", W'(ov[0]), '0);
    check("midrst_sum", s[0], '0);
    check("midrst_cout", W'(co[0]), '0);
    for (int d = 0; d < 3; d++) q[d].delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    drive_xy({(W/4){4'h9}}, {(W/4){4'h7}}, 1'b0, 1'b0, 1'b1);
    idle();
    wait_drain();
    repeat (5) @(negedge clk);

    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
